// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between the sweep controller and its environment.
// The controller is the master: it drives the vector and the result outputs.
// The slave side drives START/ABORT and returns F from the function unit.
interface truth_table_sweeper_if;
  logic        START;
  logic        ABORT;
  logic        F;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic [15:0] TT;
  logic [4:0]  FAIL_CNT;
  logic [3:0]  FAIL_IDX;

  modport master (
    input  START, ABORT, F,
    output A, B, C, D, BUSY, DONE, PASS, TT, FAIL_CNT, FAIL_IDX
  );

  modport slave (
    output START, ABORT, F,
    input  A, B, C, D, BUSY, DONE, PASS, TT, FAIL_CNT, FAIL_IDX
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 {A,B,C,D} vectors, samples F after SETTLE idle cycles, compares to EXPECTED_MASK.
// Latency: DONE rises 16*(SETTLE+1) cycles after the START edge; all outputs registered.
// No backpressure: START is ignored while running, ABORT cancels a sweep and keeps partial results.
module truth_table_sweeper #(
  parameter int unsigned SETTLE        = 2,
  parameter logic [15:0] EXPECTED_MASK = 16'hAAF8
) (
  input  logic                  CLK,
  input  logic                  RST,
  truth_table_sweeper_if.master sw
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0]  SETTLE_L = 4'(SETTLE);
  localparam logic [15:0] EXP_L    = EXPECTED_MASK;

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  fail_cnt_q, fail_cnt_d;
  logic [3:0]  fail_idx_q, fail_idx_d;
  logic        pass_q, pass_d;

  // Next-state logic: start/abort handling, settle countdown, sample-and-compare.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tt_d       = tt_q;
    fail_cnt_d = fail_cnt_q;
    fail_idx_d = fail_idx_q;
    pass_d     = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (sw.START) begin
          state_d    = S_RUN;
          idx_d      = 4'd0;
          cnt_d      = SETTLE_L;
          tt_d       = 16'h0000;
          fail_cnt_d = 5'd0;
          fail_idx_d = 4'd0;
          pass_d     = 1'b0;
        end
      end
      S_RUN: begin
        if (sw.ABORT) begin
          // Abort beats a same-edge sample; partial TT/fail stats are kept.
          state_d = S_IDLE;
          idx_d   = 4'd0;
          pass_d  = 1'b0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          tt_d[idx_q] = sw.F;
          if (sw.F != EXP_L[idx_q]) begin
            fail_cnt_d = fail_cnt_q + 5'd1;
            if (fail_cnt_q == 5'd0) begin
              fail_idx_d = idx_q;
            end
          end
          if (idx_q != 4'd15) begin
            idx_d = idx_q + 4'd1;
            cnt_d = SETTLE_L;
          end else begin
            // Vector stays at 15 in DONE until the next START or reset.
            state_d = S_DONE;
            pass_d  = (fail_cnt_d == 5'd0);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      cnt_q      <= 4'd0;
      tt_q       <= 16'h0000;
      fail_cnt_q <= 5'd0;
      fail_idx_q <= 4'd0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tt_q       <= tt_d;
      fail_cnt_q <= fail_cnt_d;
      fail_idx_q <= fail_idx_d;
      pass_q     <= pass_d;
    end
  end

  assign sw.A        = idx_q[3];
  assign sw.B        = idx_q[2];
  assign sw.C        = idx_q[1];
  assign sw.D        = idx_q[0];
  assign sw.BUSY     = (state_q == S_RUN);
  assign sw.DONE     = (state_q == S_DONE);
  assign sw.PASS     = pass_q;
  assign sw.TT       = tt_q;
  assign sw.FAIL_CNT = fail_cnt_q;
  assign sw.FAIL_IDX = fail_idx_q;

endmodule
